// File: rtl/sprite_ball_pkg.sv
// Shared types and constants for the bouncing ball sprite.
// FSM encoding, direction constants and default screen limits.
package sprite_ball_pkg;

   typedef enum logic [1:0] {
      SCAN   = 2'd0,
      UPDATE = 2'd1,
      CLEAR  = 2'd2
   } state_t;

   localparam logic LEFT  = 1'b0;
   localparam logic RIGHT = 1'b1;
   localparam logic UP    = 1'b0;
   localparam logic DOWN  = 1'b1;

   localparam int XMAX_DEF = 639;
   localparam int YMAX_DEF = 479;

endpackage

// File: rtl/ball_ring_sampler.sv
// Occupancy ring one pixel outside the ball, plus the
// per-axis blocked flags and corner-only hit detection.
module ball_ring_sampler
   import sprite_ball_pkg::*;
#(
   parameter int SIZE = 3,
   parameter int XMAX = XMAX_DEF,
   parameter int YMAX = YMAX_DEF
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       pixpulse,
   input  logic       scan,
   input  logic       clear,
   input  logic [9:0] hcount,
   input  logic [9:0] vcount,
   input  logic       empty,
   input  logic [9:0] xloc,
   input  logic [9:0] yloc,
   input  logic       xdir,
   input  logic       ydir,
   output logic       blk_x,
   output logic       blk_y,
   output logic       corner
);

   localparam int R = (SIZE - 1) / 2;
   localparam int N = SIZE + 2;

   logic [N-1:0] lft, rgt, top, bot;
   logic [10:0]  offh, offv;
   logic         hit;
   logic         lft_blk, rgt_blk, top_blk, bot_blk;
   logic         cbit;

   // 11-bit offsets so ring positions left of/above 0 wrap out of range
   assign offh = {1'b0, hcount} - {1'b0, xloc} + 11'(R + 1);
   assign offv = {1'b0, vcount} - {1'b0, yloc} + 11'(R + 1);
   assign hit  = pixpulse & ~empty & scan;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lft <= '0;
         rgt <= '0;
         top <= '0;
         bot <= '0;
      end else if (clear) begin
         lft <= '0;
         rgt <= '0;
         top <= '0;
         bot <= '0;
      end else if (hit) begin
         for (int i = 0; i < N; i++) begin
            if (offh == 11'd0 && offv == 11'(i))
               lft[i] <= 1'b1;
            if (offh == 11'(N - 1) && offv == 11'(i))
               rgt[i] <= 1'b1;
            if (offv == 11'd0 && offh == 11'(i))
               top[i] <= 1'b1;
            if (offv == 11'(N - 1) && offh == 11'(i))
               bot[i] <= 1'b1;
         end
      end
   end

   assign lft_blk = (|lft[N-2:1]) | (xloc == 10'(R));
   assign rgt_blk = (|rgt[N-2:1]) | (xloc == 10'(XMAX - R));
   assign top_blk = (|top[N-2:1]) | (yloc == 10'(R));
   assign bot_blk = (|bot[N-2:1]) | (yloc == 10'(YMAX - R));

   assign blk_x = (xdir == RIGHT) ? rgt_blk : lft_blk;
   assign blk_y = (ydir == DOWN)  ? bot_blk : top_blk;

   always_comb begin
      cbit = 1'b0;
      unique case ({xdir, ydir})
         {LEFT,  UP}:   cbit = lft[0];
         {LEFT,  DOWN}: cbit = lft[N-1];
         {RIGHT, UP}:   cbit = rgt[0];
         {RIGHT, DOWN}: cbit = rgt[N-1];
         default:       cbit = 1'b0;
      endcase
   end

   assign corner = cbit & ~blk_x & ~blk_y;

endmodule

// File: rtl/sprite_ball.sv
// Bouncing ball sprite: draw test, frame-rate divider,
// position/direction update FSM and bounce counter.
module sprite_ball
   import sprite_ball_pkg::*;
#(
   parameter int   SIZE       = 3,
   parameter int   XLOC_START = 320,
   parameter int   YLOC_START = 240,
   parameter logic XDIR_START = 1'b0,
   parameter logic YDIR_START = 1'b0,
   parameter int   XMAX       = XMAX_DEF,
   parameter int   YMAX       = YMAX_DEF,
   parameter int   DIV_W      = 4
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             pixpulse,
   input  logic [9:0]       hcount,
   input  logic [9:0]       vcount,
   input  logic             empty,
   input  logic             move,
   input  logic             pause,
   input  logic [DIV_W-1:0] speed_div,
   output logic             draw_ball,
   output logic [9:0]       xloc,
   output logic [9:0]       yloc,
   output logic             xdir,
   output logic             ydir,
   output logic             bounce,
   output logic [15:0]      bounce_count
);

   localparam int R = (SIZE - 1) / 2;
   localparam logic [9:0] XLO = 10'(R);
   localparam logic [9:0] XHI = 10'(XMAX - R);
   localparam logic [9:0] YLO = 10'(R);
   localparam logic [9:0] YHI = 10'(YMAX - R);

   state_t           state, nxt;
   logic [DIV_W-1:0] div_cnt;
   logic             go;
   logic             scan, upd, clr;
   logic             blk_x, blk_y, corner;
   logic             rev_x, rev_y, nxdir, nydir;
   logic [9:0]       nxloc, nyloc;
   logic [15:0]      bcnt, bcnt_nxt;
   logic [10:0]      dx, dy;

   assign dx = {1'b0, hcount} - {1'b0, xloc} + 11'(R);
   assign dy = {1'b0, vcount} - {1'b0, yloc} + 11'(R);
   assign draw_ball = (dx <= 11'(2 * R)) & (dy <= 11'(2 * R));

   assign go = pixpulse & move & ~pause;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= SCAN;
      else
         state <= nxt;
   end

   always_comb begin
      nxt = state;
      if (pixpulse) begin
         unique case (state)
            SCAN:    if (move & ~pause & (div_cnt == speed_div))
                        nxt = UPDATE;
            UPDATE:  nxt = CLEAR;
            CLEAR:   nxt = SCAN;
            default: nxt = SCAN;
         endcase
      end
   end

   always_comb begin
      scan   = 1'b0;
      upd    = 1'b0;
      clr    = 1'b0;
      bounce = 1'b0;
      unique case (state)
         SCAN:    scan = 1'b1;
         UPDATE:  upd  = pixpulse;
         CLEAR:   clr  = pixpulse;
         default: scan = 1'b0;
      endcase
      bounce = upd & (rev_x | rev_y);
   end

   ball_ring_sampler #(
      .SIZE (SIZE),
      .XMAX (XMAX),
      .YMAX (YMAX)
   ) u_ring (
      .clk      (clk),
      .rst      (rst),
      .pixpulse (pixpulse),
      .scan     (scan),
      .clear    (clr),
      .hcount   (hcount),
      .vcount   (vcount),
      .empty    (empty),
      .xloc     (xloc),
      .yloc     (yloc),
      .xdir     (xdir),
      .ydir     (ydir),
      .blk_x    (blk_x),
      .blk_y    (blk_y),
      .corner   (corner)
   );

   // Step after reversal; the clamp keeps the centre inside the walls
   always_comb begin
      rev_x = blk_x | corner;
      rev_y = blk_y | corner;
      nxdir = xdir ^ rev_x;
      nydir = ydir ^ rev_y;
      if (nxdir == RIGHT)
         nxloc = (xloc >= XHI) ? xloc : xloc + 10'd1;
      else
         nxloc = (xloc <= XLO) ? xloc : xloc - 10'd1;
      if (nydir == DOWN)
         nyloc = (yloc >= YHI) ? yloc : yloc + 10'd1;
      else
         nyloc = (yloc <= YLO) ? yloc : yloc - 10'd1;
   end

   // A speed_div lowered under div_cnt restarts the count
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         div_cnt <= '0;
      else if (upd)
         div_cnt <= '0;
      else if (scan & go & (div_cnt != speed_div))
         div_cnt <= (div_cnt > speed_div) ? '0 : div_cnt + DIV_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         xloc <= 10'(XLOC_START);
         yloc <= 10'(YLOC_START);
         xdir <= XDIR_START;
         ydir <= YDIR_START;
      end else if (upd) begin
         xloc <= nxloc;
         yloc <= nyloc;
         xdir <= nxdir;
         ydir <= nydir;
      end
   end

   assign bcnt_nxt = (bounce && bcnt != 16'hFFFF) ? bcnt + 16'd1 : bcnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         bcnt <= '0;
      else
         bcnt <= bcnt_nxt;
   end

   assign bounce_count = bcnt;

endmodule

// File: tb/tb_sprite_ball.sv
// Directed bench for sprite_ball: default instance plus a
// SIZE=5 instance starting on the left wall.
module tb_sprite_ball;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       move = 1'b0;
   logic       pause = 1'b0;
   logic       empty = 1'b1;
   logic [9:0] hcount = '0;
   logic [9:0] vcount = '0;
   logic [3:0] speed_div = '0;
   logic [1:0] pc = '0;
   logic       pixpulse;

   logic        a_draw, a_xdir, a_ydir, a_bounce;
   logic [9:0]  a_xloc, a_yloc;
   logic [15:0] a_cnt;
   logic        b_draw, b_xdir, b_ydir, b_bounce;
   logic [9:0]  b_xloc, b_yloc;
   logic [15:0] b_cnt;

   int tests = 0;
   int fails = 0;
   int bc_a = 0;
   int bc_b = 0;

   always #5 clk = ~clk;
   always @(posedge clk) pc <= pc + 2'd1;
   assign pixpulse = (pc == 2'd0);

   always @(negedge clk) begin
      if (a_bounce) bc_a++;
      if (b_bounce) bc_b++;
   end

   sprite_ball dut_a (
      .clk(clk), .rst(rst), .pixpulse(pixpulse),
      .hcount(hcount), .vcount(vcount), .empty(empty),
      .move(move), .pause(pause), .speed_div(speed_div),
      .draw_ball(a_draw), .xloc(a_xloc), .yloc(a_yloc),
      .xdir(a_xdir), .ydir(a_ydir), .bounce(a_bounce),
      .bounce_count(a_cnt)
   );

   sprite_ball #(.SIZE(5), .XLOC_START(2)) dut_b (
      .clk(clk), .rst(rst), .pixpulse(pixpulse),
      .hcount(hcount), .vcount(vcount), .empty(empty),
      .move(move), .pause(pause), .speed_div(speed_div),
      .draw_ball(b_draw), .xloc(b_xloc), .yloc(b_yloc),
      .xdir(b_xdir), .ydir(b_ydir), .bounce(b_bounce),
      .bounce_count(b_cnt)
   );

   // Stop at the negedge right before the next pixpulse edge
   task automatic sync();
      int k = 0;
      @(negedge clk);
      while (!pixpulse && k < 8) begin
         @(negedge clk);
         k++;
      end
      if (!pixpulse) begin
         tests++; fails++;
         $display("FAIL sync_timeout got pixpulse=%0b need 1", pixpulse);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      sync();
   endtask

   task automatic move_once();
      sync();
      move = 1'b1;
      sync();
      move = 1'b0;
      sync();
      sync();
   endtask

   task automatic obstacle(input logic [9:0] h, input logic [9:0] v);
      hcount = h;
      vcount = v;
      empty = 1'b0;
      sync();
      sync();
      empty = 1'b1;
      hcount = '0;
      vcount = '0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      tests++; if (a_xloc !== 10'd320) begin fails++; $display("FAIL rst_xloc got %0d need 320", a_xloc); end
      tests++; if (a_yloc !== 10'd240) begin fails++; $display("FAIL rst_yloc got %0d need 240", a_yloc); end
      tests++; if ({a_xdir, a_ydir} !== 2'b00) begin fails++; $display("FAIL rst_dirs got %b need 00", {a_xdir, a_ydir}); end
      tests++; if (a_bounce !== 1'b0) begin fails++; $display("FAIL rst_bounce got %b need 0", a_bounce); end
      tests++; if (a_cnt !== 16'd0) begin fails++; $display("FAIL rst_count got %h need 0000", a_cnt); end
      tests++; if (b_xloc !== 10'd2) begin fails++; $display("FAIL rst_b_xloc got %0d need 2", b_xloc); end
      hcount = 10'd321; vcount = 10'd239; #1;
      tests++; if (a_draw !== 1'b1) begin fails++; $display("FAIL draw_in got %b need 1", a_draw); end
      hcount = 10'd322; #1;
      tests++; if (a_draw !== 1'b0) begin fails++; $display("FAIL draw_out got %b need 0", a_draw); end
      hcount = 10'd319; vcount = 10'd238; #1;
      tests++; if (a_draw !== 1'b0) begin fails++; $display("FAIL draw_above got %b need 0", a_draw); end
      hcount = '0; vcount = '0;
   endtask

   task automatic test_step();
      int b0;
      do_reset();
      b0 = bc_a;
      move_once();
      tests++; if (a_xloc !== 10'd319) begin fails++; $display("FAIL step_xloc got %0d need 319", a_xloc); end
      tests++; if (a_yloc !== 10'd239) begin fails++; $display("FAIL step_yloc got %0d need 239", a_yloc); end
      tests++; if (bc_a - b0 !== 0) begin fails++; $display("FAIL step_bounce got %0d need 0", bc_a - b0); end
   endtask

   task automatic test_wall();
      int b0;
      do_reset();
      b0 = bc_b;
      move_once();
      tests++; if (b_xdir !== 1'b1) begin fails++; $display("FAIL wall_xdir got %b need 1", b_xdir); end
      tests++; if (b_xloc !== 10'd3) begin fails++; $display("FAIL wall_xloc got %0d need 3", b_xloc); end
      tests++; if (bc_b - b0 !== 1) begin fails++; $display("FAIL wall_pulses got %0d need 1", bc_b - b0); end
      tests++; if (b_cnt !== 16'd1) begin fails++; $display("FAIL wall_count got %0d need 1", b_cnt); end
   endtask

   task automatic test_corner();
      do_reset();
      obstacle(10'd318, 10'd238);
      move_once();
      tests++; if (a_xloc !== 10'd321) begin fails++; $display("FAIL corner_xloc got %0d need 321", a_xloc); end
      tests++; if (a_yloc !== 10'd241) begin fails++; $display("FAIL corner_yloc got %0d need 241", a_yloc); end
      tests++; if ({a_xdir, a_ydir} !== 2'b11) begin fails++; $display("FAIL corner_dirs got %b need 11", {a_xdir, a_ydir}); end
      tests++; if (a_cnt !== 16'd1) begin fails++; $display("FAIL corner_count got %0d need 1", a_cnt); end
   endtask

   task automatic test_divider();
      do_reset();
      speed_div = 4'd3;
      repeat (8) move_once();
      tests++; if ({a_xloc, a_yloc} !== {10'd318, 10'd238}) begin fails++; $display("FAIL div_pos got %0d,%0d need 318,238", a_xloc, a_yloc); end
      pause = 1'b1;
      repeat (4) move_once();
      tests++; if ({a_xloc, a_yloc} !== {10'd318, 10'd238}) begin fails++; $display("FAIL pause_pos got %0d,%0d need 318,238", a_xloc, a_yloc); end
      pause = 1'b0;
      speed_div = 4'd0;
   endtask

   task automatic test_reset_in_update();
      do_reset();
      obstacle(10'd318, 10'd240);
      sync();
      move = 1'b1;
      sync();
      move = 1'b0;
      tests++; if (a_bounce !== 1'b1) begin fails++; $display("FAIL upd_pending got %b need 1", a_bounce); end
      rst = 1'b1;
      #1;
      tests++; if ({a_xloc, a_yloc} !== {10'd320, 10'd240}) begin fails++; $display("FAIL abort_pos got %0d,%0d need 320,240", a_xloc, a_yloc); end
      tests++; if ({a_xdir, a_ydir} !== 2'b00) begin fails++; $display("FAIL abort_dirs got %b need 00", {a_xdir, a_ydir}); end
      tests++; if (a_bounce !== 1'b0) begin fails++; $display("FAIL abort_bounce got %b need 0", a_bounce); end
      @(negedge clk);
      rst = 1'b0;
      sync();
      tests++; if (a_cnt !== 16'd0) begin fails++; $display("FAIL abort_count got %0d need 0", a_cnt); end
   endtask

   task automatic test_saturate();
      logic [9:0] hx [3] = '{10'd318, 10'd323, 10'd318};
      logic [9:0] vy [3] = '{10'd240, 10'd239, 10'd238};
      int b0;
      do_reset();
      force dut_a.bcnt = 16'hFFFE;
      sync();
      release dut_a.bcnt;
      sync();
      tests++; if (a_cnt !== 16'hFFFE) begin fails++; $display("FAIL sat_preset got %h need fffe", a_cnt); end
      for (int i = 0; i < 3; i++) begin
         b0 = bc_a;
         obstacle(hx[i], vy[i]);
         move_once();
         tests++; if (bc_a - b0 !== 1) begin fails++; $display("FAIL sat_pulse%0d got %0d need 1", i, bc_a - b0); end
         tests++; if (a_cnt !== 16'hFFFF) begin fails++; $display("FAIL sat_count%0d got %h need ffff", i, a_cnt); end
      end
      tests++; if ({a_xloc, a_yloc} !== {10'd321, 10'd237}) begin fails++; $display("FAIL sat_pos got %0d,%0d need 321,237", a_xloc, a_yloc); end
   endtask

   initial begin
      test_reset();
      test_step();
      test_wall();
      test_corner();
      test_divider();
      test_reset_in_update();
      test_saturate();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout need finish");
      $fatal(1, "watchdog");
   end

endmodule
